icm_get_req_arbiter: RTL

// - Round-robin arbiter sharing one ICMGet request path among CHAN_NUM requesters (e.g. QPC/CQC/MTT lookup clients).
// - Sits upstream of the ICMGet request buffering thread and drives its icm_get_req_* handshake.
// - One registered output stage: full throughput, 1-cycle latency, head held stable while stalled.

---
 rtl/icm_get_req_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/icm_get_req_arbiter.sv
// icm_get_req_arbiter
// Round-robin arbiter that shares one ICMGet request path among CHAN_NUM
// requesters. It has one registered output stage, so it gives full
// throughput with a latency of one cycle, and it holds the head stable
// while the downstream stalls.
// Optional feature: define ICM_GET_ARB_STAT_EN to build per-channel
// saturating grant counters. When the macro is undefined, stat_grant_cnt
// is tied to zero.
// HEAD_WIDTH is normally derived from the head-layout macros
// (COUNT_MAX_LOG*2 + MAX_REQ_TAG_NUM_LOG + PHY_SPACE_ADDR_WIDTH + 64) and
// is overridden at instantiation.
module icm_get_req_arbiter #(
  parameter int CHAN_NUM     = 2,
  parameter int CHAN_NUM_LOG = (CHAN_NUM > 2) ? $clog2(CHAN_NUM) : 1,
  parameter int HEAD_WIDTH   = 128,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHAN_NUM-1:0]            chnl_req_valid,
  input  logic [CHAN_NUM*HEAD_WIDTH-1:0] chnl_req_head,
  output logic [CHAN_NUM-1:0]            chnl_req_ready,
  output logic                           icm_get_req_valid,
  output logic [HEAD_WIDTH-1:0]          icm_get_req_head,
  input  logic                           icm_get_req_ready,
  output logic [CHAN_NUM*CNT_WIDTH-1:0]  stat_grant_cnt
);

  logic                    valid_q, valid_d;
  logic [HEAD_WIDTH-1:0]   head_q, head_d;
  logic [CHAN_NUM_LOG-1:0] last_grant_q, last_grant_d;

  logic                    stage_free_s;
  logic                    grant_found_s;
  logic                    accept_s;
  logic [CHAN_NUM-1:0]     grant_s;
  logic [CHAN_NUM_LOG-1:0] grant_idx_s;
  logic [HEAD_WIDTH-1:0]   sel_head_s;

  // The output stage can take a new head when it is empty or draining this cycle.
  assign stage_free_s   = ~valid_q | icm_get_req_ready;
  assign chnl_req_ready = grant_s & {CHAN_NUM{stage_free_s}};
  assign accept_s       = grant_found_s & stage_free_s;

  // Round-robin search: the winner is the valid channel closest after last_grant (mod CHAN_NUM).
  always_comb begin
    int best_dist_v;
    int best_chan_v;
    int dist_v;
    grant_found_s = 1'b0;
    best_dist_v   = CHAN_NUM;
    best_chan_v   = 0;
    dist_v        = 0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      // Distance 0 is the channel right after the last winner.
      dist_v = (c + CHAN_NUM - 1 - int'(last_grant_q)) % CHAN_NUM;
      if (chnl_req_valid[c] && (dist_v < best_dist_v)) begin
        best_dist_v   = dist_v;
        best_chan_v   = c;
        grant_found_s = 1'b1;
      end else begin
        best_dist_v = best_dist_v;
      end
    end
    grant_idx_s = CHAN_NUM_LOG'(best_chan_v);
    grant_s     = '0;
    sel_head_s  = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      grant_s[c] = grant_found_s && (c == best_chan_v);
      if (c == best_chan_v) begin
        sel_head_s = chnl_req_head[c*HEAD_WIDTH +: HEAD_WIDTH];
      end else begin
        sel_head_s = sel_head_s;
      end
    end
  end

  // Next state of the output stage: load on accept, empty on drain, otherwise hold bit-stable.
  always_comb begin
    valid_d      = valid_q;
    head_d       = head_q;
    last_grant_d = last_grant_q;
    if (accept_s) begin
      valid_d      = 1'b1;
      head_d       = sel_head_s;
      last_grant_d = grant_idx_s;
    end else if (icm_get_req_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage and pointer registers; after reset channel 0 has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      head_q       <= '0;
      last_grant_q <= CHAN_NUM_LOG'(CHAN_NUM - 1);
    end else begin
      valid_q      <= valid_d;
      head_q       <= head_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign icm_get_req_valid = valid_q;
  assign icm_get_req_head  = head_q;

`ifdef ICM_GET_ARB_STAT_EN
  for (genvar g = 0; g < CHAN_NUM; g++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_q;

    // Count accepts of this channel and stop counting at all-ones.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (accept_s && grant_s[g] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end else begin
        cnt_q <= cnt_q;
      end
    end

    assign stat_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule
